fft8_stream_ctrl: RTL and testbench

- Frame sequencer that sits between a serial complex-sample stream and the parallel 8-point FFT datapath (fft8).
- Deserialises 8 input samples into a frame buffer, pulses the datapath enable once, and waits for the datapath valid.
- Captures the 8 results and re-serialises them in natural order (y0..y7) with valid/ready backpressure.
- Input and output sides run concurrently, so frame N+1 loads while frame N drains.

---
 rtl/fft8_pkg.sv | 21 ++
 rtl/fft8_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fft8_stream_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT streaming controller and its datapath.
package fft8_pkg;

    localparam int unsigned DW = 24;
    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {InLoad, InFull, InFire, InWait} in_state_e;
    typedef enum logic       {OutIdle, OutDrain}              out_state_e;

    // Element idx of a flattened N*DW bus, element 0 in the low bits.
    function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] bus, input int unsigned idx);
        return bus[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/fft8_stream_ctrl.sv
// Serial-to-frame sequencer for the parallel fft8 datapath: deserialise 8 samples, fire,
// capture the results and re-serialise them in bin order with valid/ready backpressure.
module fft8_stream_ctrl
    import fft8_pkg::*;
#(
    parameter int unsigned  DW      = fft8_pkg::DW,
    parameter int unsigned  TIMEOUT = 32,
    localparam int unsigned TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic signed [DW-1:0] i_s_real,
    input  logic signed [DW-1:0] i_s_imag,
    output logic                 o_m_valid,
    input  logic                 i_m_ready,
    output logic signed [DW-1:0] o_m_real,
    output logic signed [DW-1:0] o_m_imag,
    output logic [IW-1:0]        o_m_index,
    output logic                 o_m_last,
    output logic                 o_fft_en,
    output logic [N*DW-1:0]      o_fft_x_real,
    output logic [N*DW-1:0]      o_fft_x_imag,
    input  logic                 i_fft_valid,
    input  logic [N*DW-1:0]      i_fft_y_real,
    input  logic [N*DW-1:0]      i_fft_y_imag,
    output logic                 o_busy,
    output logic                 o_err_timeout,
    output logic                 o_err_spurious
);

    in_state_e  r_in_st;
    out_state_e r_out_st;
    logic [IW-1:0] r_icnt;
    logic [IW-1:0] r_ocnt;
    logic [TW-1:0] r_tcnt;
    logic          r_s_ready;
    logic          r_fft_en;
    logic          r_err_timeout;
    logic          r_err_spurious;

    logic signed [DW-1:0] r_ibuf_re [N];
    logic signed [DW-1:0] r_ibuf_im [N];
    logic signed [DW-1:0] r_obuf_re [N];
    logic signed [DW-1:0] r_obuf_im [N];

    logic w_s_fire;
    logic w_m_fire;
    logic w_capture;
    logic w_out_free;
    logic w_timeout;

    assign w_s_fire   = i_s_valid && r_s_ready;
    assign w_m_fire   = (r_out_st == OutDrain) && i_m_ready;
    assign w_capture  = (r_in_st == InWait) && i_fft_valid;
    // obuf is free now, or its last bin is handed over on this edge.
    assign w_out_free = (r_out_st == OutIdle) || (w_m_fire && (r_ocnt == IW'(N - 1)));
    assign w_timeout  = (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_in_st        <= InLoad;
            r_icnt         <= '0;
            r_tcnt         <= '0;
            r_s_ready      <= 1'b0;
            r_fft_en       <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_fft_en <= 1'b0;
            if (i_fft_valid && (r_in_st != InWait)) begin
                r_err_spurious <= 1'b1;
            end
            unique case (r_in_st)
                InLoad: begin
                    r_s_ready <= 1'b1;
                    if (w_s_fire) begin
                        r_icnt <= r_icnt + IW'(1);
                        if (r_icnt == IW'(N - 1)) begin
                            r_s_ready <= 1'b0;
                            if (w_out_free) begin
                                r_in_st  <= InFire;
                                r_fft_en <= 1'b1;
                            end else begin
                                r_in_st <= InFull;
                            end
                        end
                    end
                end
                InFull: begin
                    if (w_out_free) begin
                        r_in_st  <= InFire;
                        r_fft_en <= 1'b1;
                    end
                end
                InFire: begin
                    r_in_st <= InWait;
                    r_tcnt  <= '0;
                end
                InWait: begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (i_fft_valid) begin
                        r_in_st   <= InLoad;
                        r_s_ready <= 1'b1;
                    end else if (w_timeout) begin
                        r_err_timeout <= 1'b1;
                        r_in_st       <= InLoad;
                        r_s_ready     <= 1'b1;
                    end
                end
                default: r_in_st <= InLoad;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_s_fire) begin
            r_ibuf_re[r_icnt] <= i_s_real;
            r_ibuf_im[r_icnt] <= i_s_imag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            for (int i = 0; i < N; i++) begin
                r_obuf_re[i] <= i_fft_y_real[i*DW +: DW];
                r_obuf_im[i] <= i_fft_y_imag[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_out_st <= OutIdle;
            r_ocnt   <= '0;
        end else begin
            unique case (r_out_st)
                OutIdle: begin
                    if (w_capture) begin
                        r_out_st <= OutDrain;
                        r_ocnt   <= '0;
                    end
                end
                OutDrain: begin
                    if (w_m_fire) begin
                        r_ocnt <= r_ocnt + IW'(1);
                        if (r_ocnt == IW'(N - 1)) begin
                            r_out_st <= OutIdle;
                        end
                    end
                end
                default: r_out_st <= OutIdle;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_xbus
        assign o_fft_x_real[g*DW +: DW] = r_ibuf_re[g];
        assign o_fft_x_imag[g*DW +: DW] = r_ibuf_im[g];
    end

    assign o_s_ready      = r_s_ready;
    assign o_fft_en       = r_fft_en;
    assign o_m_valid      = (r_out_st == OutDrain);
    assign o_m_real       = r_obuf_re[r_ocnt];
    assign o_m_imag       = r_obuf_im[r_ocnt];
    assign o_m_index      = r_ocnt;
    assign o_m_last       = (r_ocnt == IW'(N - 1));
    assign o_busy         = !((r_in_st == InLoad) && (r_icnt == '0)) || (r_out_st != OutIdle);
    assign o_err_timeout  = r_err_timeout;
    assign o_err_spurious = r_err_spurious;

endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Bench for fft8_stream_ctrl: DFT datapath model, frame-level scoreboard and directed corners.
module tb_fft8_stream_ctrl;
    import fft8_pkg::*;

    localparam int unsigned TIMEOUT = 32;
    localparam int          LAT     = 4;
    localparam int          RMAX    = 262144;

    typedef struct { int xr; int xi; int yr; int yi; } vec_t;
    typedef struct { cplx_t v; int idx; bit last; int cyc; } rec_t;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_real = '0;
    logic signed [DW-1:0] s_imag = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic signed [DW-1:0] m_real;
    logic signed [DW-1:0] m_imag;
    logic [IW-1:0]        m_index;
    logic                 m_last;
    logic                 fft_en;
    logic [N*DW-1:0]      fft_x_real;
    logic [N*DW-1:0]      fft_x_imag;
    logic                 fft_valid;
    logic                 dp_valid = 1'b0;
    logic                 spur_valid = 1'b0;
    logic [N*DW-1:0]      fft_y_real = '0;
    logic [N*DW-1:0]      fft_y_imag = '0;
    logic                 busy;
    logic                 err_timeout;
    logic                 err_spurious;

    assign fft_valid = dp_valid | spur_valid;

    always #5 clk = ~clk;

    fft8_stream_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) u_dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_real(s_real), .i_s_imag(s_imag),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_real(m_real), .o_m_imag(m_imag),
        .o_m_index(m_index), .o_m_last(m_last),
        .o_fft_en(fft_en), .o_fft_x_real(fft_x_real), .o_fft_x_imag(fft_x_imag),
        .i_fft_valid(fft_valid), .i_fft_y_real(fft_y_real), .i_fft_y_imag(fft_y_imag),
        .o_busy(busy), .o_err_timeout(err_timeout), .o_err_spurious(err_spurious)
    );

    int    checks = 0, failures = 0, cyc = 0;
    int    en_count = 0, en_cyc = -1, last_acc_cyc = -1, hs_count = 0, dp_timer = 0;
    int    pat_idx = 0;
    bit    dp_on = 1'b1, acc_now = 1'b0, hold_pend = 1'b0, exp_first = 1'b0;
    bit    rand_ready = 1'b0, pat_on = 1'b0;
    rec_t  hold_rec;
    cplx_t acc_q[$];
    rec_t  exp_q[$];
    rec_t  log_q[$];
    int    hs7_q[$];
    cplx_t dp_x[N];
    vec_t  tbl[N];

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    // Reference 8-point DFT, rounded to the nearest integer per component.
    task automatic dft(input cplx_t x[N], output cplx_t y[N]);
        for (int k = 0; k < N; k++) begin
            real ar = 0.0, ai = 0.0;
            for (int n = 0; n < N; n++) begin
                real th = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
                real xr = real'(sx(x[n].re));
                real xi = real'(sx(x[n].im));
                ar += xr * $cos(th) + xi * $sin(th);
                ai += xi * $cos(th) - xr * $sin(th);
            end
            y[k].re = DW'(rnd(ar));
            y[k].im = DW'(rnd(ai));
        end
    endtask

    task automatic step();
        cplx_t c;
        cplx_t fr[N];
        cplx_t fy[N];
        rec_t  e;
        @(negedge clk);
        cyc++;
        acc_now = 1'b0;
        if (rstn) begin
            if (hold_pend) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_real", sx(m_real), sx(hold_rec.v.re));
                chk("hold_imag", sx(m_imag), sx(hold_rec.v.im));
                chk("hold_index", int'(m_index), hold_rec.idx);
                hold_pend = 1'b0;
            end
            if (exp_first) begin
                chk("first_valid", int'(m_valid), 1);
                chk("first_index", int'(m_index), 0);
                exp_first = 1'b0;
            end
            if (fft_en) begin
                en_count++;
                en_cyc = cyc;
                if (dp_on) begin
                    for (int i = 0; i < N; i++) begin
                        dp_x[i].re = slice(fft_x_real, i);
                        dp_x[i].im = slice(fft_x_imag, i);
                    end
                    dp_timer = LAT;
                end
            end
            if (s_valid && s_ready) begin
                c.re = s_real;
                c.im = s_imag;
                acc_q.push_back(c);
                acc_now = 1'b1;
                if (acc_q.size() % N == 0) last_acc_cyc = cyc;
            end
            if (dp_valid) begin
                chk("dp_frame_ready", int'(acc_q.size() >= N), 1);
                if (acc_q.size() >= N) begin
                    for (int i = 0; i < N; i++) fr[i] = acc_q.pop_front();
                    dft(fr, fy);
                    for (int i = 0; i < N; i++) begin
                        e.v = fy[i]; e.idx = i; e.last = (i == N - 1); e.cyc = 0;
                        exp_q.push_back(e);
                    end
                end
                exp_first = 1'b1;
            end
            if (m_valid) begin
                chk("out_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0 && m_ready) begin
                    e = exp_q.pop_front();
                    chk("out_real", sx(m_real), sx(e.v.re));
                    chk("out_imag", sx(m_imag), sx(e.v.im));
                    chk("out_index", int'(m_index), e.idx);
                    chk("out_last", int'(m_last), int'(e.last));
                    e.v.re = m_real; e.v.im = m_imag; e.idx = int'(m_index);
                    e.last = m_last; e.cyc = cyc;
                    log_q.push_back(e);
                    hs_count++;
                    if (m_last) hs7_q.push_back(cyc);
                end else if (!m_ready) begin
                    hold_pend = 1'b1;
                    hold_rec.v.re = m_real;
                    hold_rec.v.im = m_imag;
                    hold_rec.idx = int'(m_index);
                end
            end
        end
        @(posedge clk);
        #1;
        dp_valid = 1'b0;
        if (dp_timer > 0) begin
            dp_timer--;
            if (dp_timer == 0) begin
                dft(dp_x, fy);
                for (int i = 0; i < N; i++) begin
                    fft_y_real[i*DW +: DW] = fy[i].re;
                    fft_y_imag[i*DW +: DW] = fy[i].im;
                end
                dp_valid = 1'b1;
            end
        end
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        if (pat_on) begin
            m_ready = (pat_idx % 3 == 0);
            pat_idx++;
        end
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0; s_valid = 1'b0; spur_valid = 1'b0; dp_timer = 0; dp_valid = 1'b0;
        repeat (n) step();
        acc_q.delete(); exp_q.delete(); hold_pend = 1'b0; exp_first = 1'b0;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_m_index", int'(m_index), 0);
        chk("rst_fft_en", int'(fft_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err_timeout", int'(err_timeout), 0);
        chk("rst_err_spurious", int'(err_spurious), 0);
        rstn = 1'b1;
        step();
        chk("rst_release_s_ready", int'(s_ready), 1);
    endtask

    task automatic send_sample(input cplx_t c, input bit gaps);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) step();
        s_valid = 1'b1; s_real = c.re; s_imag = c.im;
        do begin step(); t++; end while (!acc_now && t < 300);
        s_valid = 1'b0;
        chk("send_accept", int'(acc_now), 1);
    endtask

    task automatic send_frame(input cplx_t x[N], input bit gaps);
        for (int i = 0; i < N; i++) send_sample(x[i], gaps);
    endtask

    task automatic rand_frame(output cplx_t x[N]);
        for (int i = 0; i < N; i++) begin
            x[i].re = DW'(int'($urandom_range(0, 2 * RMAX)) - RMAX);
            x[i].im = DW'(int'($urandom_range(0, 2 * RMAX)) - RMAX);
        end
    endtask

    task automatic wait_drain(input int bound);
        int t = 0;
        while ((busy || exp_q.size() != 0 || dp_timer != 0 || dp_valid) && t < bound) begin
            step(); t++;
        end
        chk("drain_in_time", int'(t < bound), 1);
    endtask

    initial begin
        cplx_t x[N];
        cplx_t b[N];
        int    en0, hs0, c0, t;

        do_reset(2);

        // Single frame x_i = (i+1, 0): y_0 = 36, y_k = -4 + j*4*cot(pi*k/8).
        tbl[0] = '{1, 0, 36, 0};   tbl[1] = '{2, 0, -4, 10};
        tbl[2] = '{3, 0, -4, 4};   tbl[3] = '{4, 0, -4, 2};
        tbl[4] = '{5, 0, -4, 0};   tbl[5] = '{6, 0, -4, -2};
        tbl[6] = '{7, 0, -4, -4};  tbl[7] = '{8, 0, -4, -10};
        for (int i = 0; i < N; i++) begin
            x[i].re = DW'(tbl[i].xr);
            x[i].im = DW'(tbl[i].xi);
        end
        m_ready = 1'b1; en0 = en_count; log_q.delete();
        send_frame(x, 1'b0);
        wait_drain(200);
        chk("t1_fft_en_pulses", en_count - en0, 1);
        chk("t1_fft_en_latency", en_cyc, last_acc_cyc + 1);
        chk("t1_out_count", log_q.size(), N);
        for (int i = 0; i < N && i < log_q.size(); i++) begin
            chk("t1_tbl_real", sx(log_q[i].v.re), tbl[i].yr);
            chk("t1_tbl_imag", sx(log_q[i].v.im), tbl[i].yi);
            chk("t1_tbl_index", log_q[i].idx, i);
            chk("t1_tbl_last", int'(log_q[i].last), int'(i == N - 1));
        end

        // Backpressure with ready pattern 1,0,0 repeating.
        rand_frame(x);
        hs0 = hs_count; pat_idx = 0; pat_on = 1'b1;
        send_frame(x, 1'b0);
        wait_drain(300);
        pat_on = 1'b0; m_ready = 1'b1;
        chk("t2_handshakes", hs_count - hs0, N);

        // Overlap: frame B loads while frame A is stalled in DRAIN.
        rand_frame(x); rand_frame(b);
        m_ready = 1'b0; hs0 = hs_count;
        send_frame(x, 1'b0);
        t = 0;
        while (!m_valid && t < 100) begin step(); t++; end
        chk("t3_a_valid", int'(m_valid), 1);
        en0 = en_count; c0 = cyc;
        send_frame(b, 1'b0);
        step(); step();
        chk("t3_full_s_ready", int'(s_ready), 0);
        chk("t3_busy", int'(busy), 1);
        while (cyc - c0 < 20) step();
        chk("t3_fire_withheld", en_count - en0, 0);
        hs7_q.delete();
        m_ready = 1'b1;
        wait_drain(300);
        chk("t3_handshakes", hs_count - hs0, 2 * N);
        chk("t3_fire_count", en_count - en0, 1);
        chk("t3_last_seen", hs7_q.size(), 2);
        if (hs7_q.size() > 0) chk("t3_fire_after_last", en_cyc, hs7_q[0] + 1);

        // Timeout: datapath never answers.
        dp_on = 1'b0; en0 = en_count; hs0 = hs_count;
        rand_frame(x);
        send_frame(x, 1'b0);
        t = 0;
        while (!err_timeout && t < 100) begin step(); t++; end
        chk("t4_err_cycle", cyc + 1, last_acc_cyc + 2 + int'(TIMEOUT));
        chk("t4_s_ready", int'(s_ready), 1);
        chk("t4_m_valid", int'(m_valid), 0);
        chk("t4_fire_count", en_count - en0, 1);
        if (acc_q.size() >= N) repeat (N) void'(acc_q.pop_front());
        dp_on = 1'b1;
        rand_frame(x);
        send_frame(x, 1'b1);
        wait_drain(300);
        chk("t4_next_frame", hs_count - hs0, N);
        chk("t4_err_sticky", int'(err_timeout), 1);

        // Spurious fft_valid while loading.
        hs0 = hs_count;
        spur_valid = 1'b1; step(); spur_valid = 1'b0;
        repeat (3) step();
        chk("t5_err_spurious", int'(err_spurious), 1);
        chk("t5_no_output", int'(m_valid), 0);
        chk("t5_not_busy", int'(busy), 0);
        chk("t5_no_handshake", hs_count - hs0, 0);

        // Reset after 5 accepted samples, then a fresh frame.
        rand_frame(x);
        for (int i = 0; i < 5; i++) send_sample(x[i], 1'b0);
        do_reset(1);
        en0 = en_count; hs0 = hs_count;
        rand_frame(x);
        send_frame(x, 1'b0);
        wait_drain(300);
        chk("t6_fire_count", en_count - en0, 1);
        chk("t6_handshakes", hs_count - hs0, N);

        // Random frames with random input gaps and output backpressure.
        hs0 = hs_count; rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            rand_frame(x);
            send_frame(x, 1'b1);
        end
        wait_drain(3000);
        rand_ready = 1'b0; m_ready = 1'b1;
        chk("t7_handshakes", hs_count - hs0, 6 * N);
        chk("t7_no_timeout", int'(err_timeout), 0);
        chk("t7_no_spurious", int'(err_spurious), 0);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
